// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and data load/store. One transaction outstanding at a time; data has priority
// unless fetch has been passed over STARVE_MAX times in a row.
// Optional watchdog: define ARB_WDOG_EN to abort a WAIT state after WDOG_CYCLES.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int STARVE_MAX  = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_fe,
    output logic            stall_mem,
    output logic            arb_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          owner_we;
    logic          arb_en;
    logic          starved;
    logic          sel_d;
    logic          sel_i;
    logic          accept;
    logic          abort;

    if (STARVE_MAX < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_MAX and WDOG_CYCLES must be >= 1");
    end

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        if (v >= SW'(STARVE_MAX))
            return SW'(STARVE_MAX);
        else
            return v + 1'b1;
    endfunction

    // Arbitration and memory-side drive; gated by reset so nothing leaks out while held
    always_comb begin
        arb_en    = (state == IDLE) && reset;
        starved   = (starve_cnt >= SW'(STARVE_MAX));
        sel_d     = arb_en && d_req && (!if_req || !starved);
        sel_i     = arb_en && !sel_d && if_req;
        mem_req   = sel_d || sel_i;
        mem_we    = sel_d && d_we;
        mem_addr  = sel_d ? d_addr : (sel_i ? if_addr : '0);
        mem_wdata = sel_d ? d_wdata : '0;
        mem_be    = sel_d ? d_be : (sel_i ? '1 : '0);
        accept    = mem_req && mem_ready;
    end

`ifdef ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    // Count WAIT cycles; cleared on every accept so each transaction starts fresh
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wdog_cnt <= '0;
        else if (accept)
            wdog_cnt <= '0;
        else if (state != IDLE && wdog_cnt != WW'(WDOG_CYCLES))
            wdog_cnt <= wdog_cnt + 1'b1;
    end

    assign abort = (state != IDLE) && !mem_rvalid && (wdog_cnt == WW'(WDOG_CYCLES));
`else
    assign abort = 1'b0;
`endif

    assign arb_err = abort;

    // Response routing: same-cycle pass-through of the memory response to the owner
    always_comb begin
        if_rvalid = (state == WAIT_I) && (mem_rvalid || abort);
        d_rvalid  = (state == WAIT_D) && (mem_rvalid || abort);
        if_rdata  = ((state == WAIT_I) && mem_rvalid) ? mem_rdata : '0;
        d_rdata   = ((state == WAIT_D) && mem_rvalid && !owner_we) ? mem_rdata : '0;
        stall_fe  = if_req && !if_rvalid;
        stall_mem = d_req && !d_rvalid;
    end

    // Ownership FSM: one outstanding transaction, released by response or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= sel_d ? WAIT_D : WAIT_I;
                        owner_we <= sel_d && d_we;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (mem_rvalid || abort) begin
                        state    <= IDLE;
                        owner_we <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    owner_we <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: data wins over a waiting fetch, reset once fetch is served or gone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!if_req)
            starve_cnt <= '0;
        else if (accept && sel_i)
            starve_cnt <= '0;
        else if (accept && sel_d)
            starve_cnt <= sat_inc(starve_cnt);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester threads push expected read
// data into per-port queues; a monitor pops and compares on every rvalid pulse.
// A behavioural memory logs each accepted request for grant-order checks.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          stall_fe;
    logic          stall_mem;
    logic          arb_err;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(4), .WDOG_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_fe(stall_fe), .stall_mem(stall_mem), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            cyc;
    } grant_t;

    grant_t        glog[$];
    logic [DW-1:0] exp_i[$];
    logic [DW-1:0] exp_d[$];

    int last_i_cyc = -1;
    int last_d_cyc = -1;
    int err_cnt = 0;
    int err_cyc = -1;
    int stall_fe_cnt = 0;
    int stall_mem_cnt = 0;

    // memory model controls
    int            lat = 1;
    bit            resp_en = 1'b1;
    int            cd = -1;
    logic [DW-1:0] pend_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_2000: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Behavioural memory: logs accepts, answers after 'lat' cycles, junk data when idle
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_ready) begin
                grant_t g;
                g.we = mem_we; g.addr = mem_addr; g.wdata = mem_wdata; g.be = mem_be; g.cyc = cyc;
                glog.push_back(g);
                if (resp_en) begin
                    cd = lat;
                    pend_data = mem_we ? 32'hFFFF_FFFF : mem_model(mem_addr);
                end
            end
            @(posedge clk);
            #1;
            if (cd > 0) cd--;
            if (cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                cd         = -1;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: pops the scoreboard on every response pulse
    initial begin
        forever begin
            @(negedge clk);
            if (if_rvalid) begin
                last_i_cyc = cyc;
                if (exp_i.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL if_unexpected: got if_rvalid data 0x%0h, want no response (cycle %0d)", if_rdata, cyc);
                end else begin
                    check("if_rdata", if_rdata, exp_i.pop_front());
                end
            end else begin
                check("if_rdata_idle", if_rdata, 0);
            end
            if (d_rvalid) begin
                last_d_cyc = cyc;
                if (exp_d.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL d_unexpected: got d_rvalid data 0x%0h, want no response (cycle %0d)", d_rdata, cyc);
                end else begin
                    check("d_rdata", d_rdata, exp_d.pop_front());
                end
            end else begin
                check("d_rdata_idle", d_rdata, 0);
            end
            if (stall_fe)  stall_fe_cnt++;
            if (stall_mem) stall_mem_cnt++;
            if (arb_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic fetch_burst(input int n, input logic [AW-1:0] a, input logic [DW-1:0] data);
        for (int k = 0; k < n; k++) exp_i.push_back(data);
        if_addr = a;
        if_req  = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!if_rvalid && t < 200);
            if (!if_rvalid) begin
                n_cmp++; n_bad++;
                $display("FAIL fetch_timeout: got no if_rvalid, want one within 200 cycles");
                break;
            end
            @(posedge clk);
            #1;
        end
        if_req  = 1'b0;
        if_addr = '0;
    endtask

    task automatic data_burst(input int n, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [BW-1:0] be,
                              input logic [DW-1:0] rd);
        for (int k = 0; k < n; k++) exp_d.push_back(rd);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_be    = be;
        d_req   = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!d_rvalid && t < 200);
            if (!d_rvalid) begin
                n_cmp++; n_bad++;
                $display("FAIL data_timeout: got no d_rvalid, want one within 200 cycles");
                break;
            end
            @(posedge clk);
            #1;
        end
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_be    = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of run, want $finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] order3 [10];
        int            t;

        reset = 1'b0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_be",    mem_be,    0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid",  d_rvalid,  0);
        check("rst_arb_err",   arb_err,   0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: lone fetch, memory answers 3 cycles after accept -> stall_fe 3 cycles
        lat = 3; glog.delete(); stall_fe_cnt = 0;
        fetch_burst(1, 32'h100, 32'h0050_0093);
        check("t1_stall_fe_cycles", stall_fe_cnt, 3);
        check("t1_grants", glog.size(), 1);
        if (glog.size() >= 1) begin
            check("t1_addr", glog[0].addr, 32'h100);
            check("t1_we",   glog[0].we,   0);
            check("t1_be",   glog[0].be,   4'hF);
        end

        // 2: fetch and load together -> data first, fetch accepted the cycle after d_rvalid
        lat = 1; glog.delete();
        fork
            fetch_burst(1, 32'h100, 32'h0050_0093);
            data_burst(1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h1234_5678);
        join
        check("t2_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("t2_first_addr",  glog[0].addr, 32'h2000);
            check("t2_second_addr", glog[1].addr, 32'h100);
            check("t2_gap",         glog[1].cyc - glog[0].cyc, 2);
            check("t2_d_before_i",  last_i_cyc - last_d_cyc, 2);
        end

        // 3: both held, 1-cycle memory -> D,D,D,D,I then counter restarts: D,D,D,D,I
        lat = 1; glog.delete();
        order3 = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h100,
                   32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h100};
        fork
            fetch_burst(2, 32'h100, 32'h0050_0093);
            data_burst(8, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h1234_5678);
        join
        check("t3_grants", glog.size(), 10);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            check($sformatf("t3_grant%0d", k), glog[k].addr, order3[k]);

        // 4: store -> write strobe, byte enables passed, ack with d_rdata 0
        lat = 1; glog.delete(); stall_mem_cnt = 0;
        data_burst(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        check("t4_stall_mem_cycles", stall_mem_cnt, 1);
        if (glog.size() >= 1) begin
            check("t4_we",    glog[0].we,    1);
            check("t4_addr",  glog[0].addr,  32'h40);
            check("t4_wdata", glog[0].wdata, 32'hDEAD_BEEF);
            check("t4_be",    glog[0].be,    4'b0011);
        end else begin
            check("t4_grants", glog.size(), 1);
        end

        // 7: no accept while mem_ready=0; selection moves to data once d_req appears
        lat = 1; glog.delete(); mem_ready = 1'b0;
        fork
            fetch_burst(1, 32'h104, 32'h00A0_0113);
            begin
                @(negedge clk);
                check("t7_sel_i", {mem_req, mem_addr}, {1'b1, 32'h104});
                @(posedge clk); #1;
                data_burst(1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h1234_5678);
            end
            begin
                repeat (2) @(negedge clk);
                check("t7_sel_d", {mem_req, mem_addr}, {1'b1, 32'h2000});
                @(posedge clk); #1;
                mem_ready = 1'b1;
            end
        join
        check("t7_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("t7_first",  glog[0].addr, 32'h2000);
            check("t7_second", glog[1].addr, 32'h104);
        end

        // 5: reset pulse during WAIT_D abandons the load; stale response is ignored
        lat = 6; glog.delete();
        d_we = 1'b0; d_addr = 32'h2000; d_req = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (glog.size() == 0 && t < 50);
        check("t5_accepted", glog.size(), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_mem_req",  mem_req,  0);
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_d_rvalid", d_rvalid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        d_req = 1'b0; d_addr = '0;
        repeat (8) @(posedge clk);
        #1;
        lat = 1; glog.delete();
        fetch_burst(1, 32'h104, 32'h00A0_0113);
        if (glog.size() >= 1) check("t5_next_addr", glog[0].addr, 32'h104);
        else check("t5_next_grants", glog.size(), 1);

`ifdef ARB_WDOG_EN
        // 6: memory stays silent past the watchdog; late answer arrives in IDLE
        lat = 12; glog.delete(); err_cnt = 0;
        data_burst(1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h0);
        check("t6_err_pulses", err_cnt, 1);
        if (glog.size() >= 1) check("t6_abort_delay", err_cyc - glog[0].cyc, 9);
        check("t6_err_with_rvalid", err_cyc, last_d_cyc);
        repeat (6) @(posedge clk);
        #1;
        lat = 1;
`else
        check("no_arb_err", err_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        check("exp_i_left", exp_i.size(), 0);
        check("exp_d_left", exp_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
